bcd_display_formatter: RTL and testbench

Sequential binary-to-BCD converter that sits directly upstream of the 8-digit multiplexed seven-segment driver. It accepts an unsigned binary count and runs a shift-add-3 (double-dabble) conversion, one bit per clock. It produces the packed 32-bit nibble word that the display driver consumes on its `encoded` input, and holds the last result stable between conversions so the display never shows partial values.

---
 rtl/bcd_display_formatter_if.sv | 23 ++
 rtl/bcd_display_formatter.sv | 86 ++++++++
 tb/tb_bcd_display_formatter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bcd_display_formatter_if.sv
// Handshake and result bus between the BCD formatter and its producer/consumer.
// master drives start/bin; slave (the formatter) drives busy/done/overflow/encoded.
interface bcd_display_formatter_if #(
  parameter int IN_WIDTH = 27,
  parameter int DIGITS   = 8
);
  logic                  start;
  logic [IN_WIDTH-1:0]   bin;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   encoded;

  modport master (
    output start, bin,
    input  busy, done, overflow, encoded
  );

  modport slave (
    input  start, bin,
    output busy, done, overflow, encoded
  );
endinterface

// File: rtl/bcd_display_formatter.sv
// Sequential double-dabble binary-to-BCD converter feeding the 8-digit display.
// Build option: define BCD_OVERFLOW_SAT_EN to saturate encoded to all nines on overflow.
module bcd_display_formatter #(
  parameter int IN_WIDTH = 27,
  parameter int DIGITS   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  bcd_display_formatter_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for start; result registers hold last conversion
  // SHIFT | one add-3/shift step per cycle, IN_WIDTH cycles
  // DONE  | one-cycle done pulse, result registers just loaded
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // One extra digit above the display width catches values >= 10^DIGITS.
  localparam int SW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(IN_WIDTH + 1);

  logic [1:0]          r_state;
  logic [IN_WIDTH-1:0] r_shift;
  logic [SW-1:0]       r_scratch;
  logic [CW-1:0]       r_cnt;
  logic [4*DIGITS-1:0] r_encoded;
  logic                r_overflow;

  logic [SW-1:0]       w_adj;
  logic [SW-1:0]       w_scratch_next;
  logic                w_ovf_next;

  for (genvar d = 0; d < DIGITS + 1; d++) begin : g_adj
    assign w_adj[4*d +: 4] = (r_scratch[4*d +: 4] >= 4'd5) ? r_scratch[4*d +: 4] + 4'd3
                                                           : r_scratch[4*d +: 4];
  end

  assign w_scratch_next = (w_adj << 1) | {{(SW-1){1'b0}}, r_shift[IN_WIDTH-1]};
  assign w_ovf_next     = (w_scratch_next[SW-1 -: 4] != 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_encoded  <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_shift   <= bus.bin;
            r_scratch <= '0;
            r_cnt     <= CW'(IN_WIDTH);
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_scratch <= w_scratch_next;
          r_shift   <= r_shift << 1;
          r_cnt     <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state    <= DONE;
            r_overflow <= w_ovf_next;
`ifdef BCD_OVERFLOW_SAT_EN
            r_encoded  <= w_ovf_next ? {DIGITS{4'h9}} : w_scratch_next[4*DIGITS-1:0];
`else
            r_encoded  <= w_scratch_next[4*DIGITS-1:0];
`endif
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (r_state == SHIFT);
  assign bus.done     = (r_state == DONE);
  assign bus.overflow = r_overflow;
  assign bus.encoded  = r_encoded;

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Directed self-checking bench for bcd_display_formatter (default 27-bit input, 8 digits).
module tb_bcd_display_formatter;
  localparam int IN_WIDTH = 27;
  localparam int DIGITS   = 8;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  bcd_display_formatter_if #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) bus ();

  bcd_display_formatter #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first SHIFT cycle (N+1).
  task automatic start_conv(input logic [IN_WIDTH-1:0] val);
    bus.bin   = val;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Called in cycle N+1; returns cycle offset of done and busy cycle count.
  task automatic wait_done(output int lat, output int busy_n, output bit to);
    lat = 1; busy_n = 0; to = 1'b0;
    while (bus.done !== 1'b1) begin
      if (bus.busy === 1'b1) busy_n++;
      if (lat > 100) begin
        to = 1'b1;
        break;
      end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat, bn; bit to;
    reset = 1'b1; bus.start = 1'b0; bus.bin = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.encoded !== 32'h0) begin n_bad++; $display("FAIL rst_encoded got %h want 00000000", bus.encoded); end
    n_cmp++; if ({bus.busy, bus.done, bus.overflow} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got %b want 000", {bus.busy, bus.done, bus.overflow}); end
    start_conv('0);
    wait_done(lat, bn, to);
    n_cmp++; if (to || lat != 28) begin n_bad++; $display("FAIL zero_latency got %0d (timeout %0d) want 28", lat, to); end
    n_cmp++; if (bus.encoded !== 32'h0) begin n_bad++; $display("FAIL zero_encoded got %h want 00000000", bus.encoded); end
    tick();
  endtask

  task automatic test_convert();
    int lat, bn; bit to;
    start_conv(27'd12345678);
    wait_done(lat, bn, to);
    n_cmp++; if (to || lat != 28) begin n_bad++; $display("FAIL conv_latency got %0d want 28", lat); end
    n_cmp++; if (bn != 27) begin n_bad++; $display("FAIL conv_busy_cycles got %0d want 27", bn); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL conv_busy_in_done got %b want 0", bus.busy); end
    n_cmp++; if (bus.encoded !== 32'h12345678) begin n_bad++; $display("FAIL conv_encoded got %h want 12345678", bus.encoded); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL conv_overflow got %b want 0", bus.overflow); end
    tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL conv_done_width got %b want 0", bus.done); end
    n_cmp++; if (bus.encoded !== 32'h12345678) begin n_bad++; $display("FAIL conv_hold got %h want 12345678", bus.encoded); end
  endtask

  task automatic test_overflow();
    int lat, bn; bit to;
    logic [31:0] exp_enc;
    start_conv(27'd99999999);
    wait_done(lat, bn, to);
    n_cmp++; if (to || bus.encoded !== 32'h99999999) begin n_bad++; $display("FAIL max_encoded got %h want 99999999", bus.encoded); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL max_overflow got %b want 0", bus.overflow); end
    tick();
`ifdef BCD_OVERFLOW_SAT_EN
    exp_enc = 32'h99999999;
`else
    exp_enc = 32'h34217727;
`endif
    start_conv(27'd134217727);
    wait_done(lat, bn, to);
    n_cmp++; if (to || bus.encoded !== exp_enc) begin n_bad++; $display("FAIL ovf_encoded got %h want %h", bus.encoded, exp_enc); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
    tick();
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_hold got %b want 1", bus.overflow); end
  endtask

  task automatic test_back_to_back();
    int lat, bn, n_done; bit to;
    logic [31:0] enc_at_done;
    n_done = 0; enc_at_done = '0;
    start_conv(27'd42);
    for (int c = 1; c <= 29; c++) begin
      if (bus.done === 1'b1) begin
        n_done++;
        enc_at_done = bus.encoded;
        n_cmp++; if (c != 28) begin n_bad++; $display("FAIL b2b_done_cycle got %0d want 28", c); end
      end
      bus.start = 1'b0;
      if (c == 4)  begin bus.start = 1'b1; bus.bin = 27'd7; end
      if (c == 10) bus.bin = 27'd999;
      if (c >= 27) begin bus.start = 1'b1; bus.bin = 27'd305; end
      tick();
    end
    bus.start = 1'b0;
    n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL b2b_done_count got %0d want 1", n_done); end
    n_cmp++; if (enc_at_done !== 32'h00000042) begin n_bad++; $display("FAIL b2b_encoded got %h want 00000042", enc_at_done); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_overflow_clear got %b want 0", bus.overflow); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_accept got %b want 1", bus.busy); end
    wait_done(lat, bn, to);
    n_cmp++; if (to || lat != 28) begin n_bad++; $display("FAIL b2b_second_latency got %0d want 28", lat); end
    n_cmp++; if (bus.encoded !== 32'h00000305) begin n_bad++; $display("FAIL b2b_second_encoded got %h want 00000305", bus.encoded); end
    tick();
  endtask

  task automatic test_reset_abort();
    int lat, bn, n_done; bit to;
    n_done = 0;
    start_conv(27'd55555);
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.encoded !== 32'h0) begin n_bad++; $display("FAIL abort_encoded got %h want 00000000", bus.encoded); end
    for (int c = 0; c < 40; c++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
      tick();
    end
    n_cmp++; if (n_done != 0) begin n_bad++; $display("FAIL abort_activity got %0d want 0", n_done); end
    start_conv(27'd9);
    wait_done(lat, bn, to);
    n_cmp++; if (to || bus.encoded !== 32'h00000009) begin n_bad++; $display("FAIL abort_restart got %h want 00000009", bus.encoded); end
    tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; bus.start = 1'b0; bus.bin = '0;
    test_reset();
    test_convert();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
